// File: rtl/adder_pkg.sv
// Shared definitions for the ADDER/ family of bit-serial arithmetic blocks.
// Holds the FSM state encoding used by the serial engines.
package adder_pkg;

    // Sequencer states for the bit-serial engines (IDLE -> RUN -> DONE -> IDLE).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : adder_pkg

// File: rtl/serial_subtractor_half_subtractor.sv
// half_subtractor: one-bit A - B without borrow-in.
// Ports:
//   A, B    in  minuend / subtrahend bit
//   Diff    out A ^ B
//   Borrow  out 1 when A=0 and B=1
// Two instances plus an OR make a full subtractor cell.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic Diff,
    output logic Borrow
);

    assign Diff   = A ^ B;
    assign Borrow = ~A & B;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, Diff = A - B, LSB first,
// one bit per clock, with borrow-out.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake; A/B sampled on the accept edge
//   A, B                WIDTH-bit unsigned minuend / subtrahend
//   out_valid/out_ready result handshake; Diff/Borrow held while out_valid
//   Diff                (A - B) mod 2**WIDTH
//   Borrow              1 iff A < B
module serial_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bw_q, bw_d;
    logic             borrow_q, borrow_d;

    // Full subtractor cell on the current LSBs and the running borrow.
    logic hd0, hb0, hb1, bit_d, bw_next;

    half_subtractor u_hs0 (
        .A      (a_q[0]),
        .B      (b_q[0]),
        .Diff   (hd0),
        .Borrow (hb0)
    );

    half_subtractor u_hs1 (
        .A      (hd0),
        .B      (bw_q),
        .Diff   (bit_d),
        .Borrow (hb1)
    );

    assign bw_next = hb0 | hb1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bw_d     = bw_q;
        borrow_d = borrow_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                // New bit enters at the MSB; after WIDTH shifts bit 0 lands in Diff[0].
                diff_d = (diff_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
                bw_d   = bw_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    borrow_d = bw_next;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bw_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bw_q     <= bw_d;
            borrow_q <= borrow_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Diff      = diff_q;
    assign Borrow    = borrow_q;

endmodule : serial_subtractor
